tag_sysid_read_arbiter: RTL



---
 rtl/tag_sysid_read_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tag_sysid_read_arbiter.sv
// Round-robin arbiter sharing the combinational system-ID slave between two Avalon-MM read masters.
// Optional boot-time ID check is enabled by defining TAG_SYSID_ID_CHECK_EN.
module tag_sysid_read_arbiter #(
    parameter int unsigned         DATA_W      = 32,
    parameter logic [DATA_W-1:0]   EXPECTED_ID = DATA_W'(32'h6073B074)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              sysid_address,
    input  logic [DATA_W-1:0] sysid_readdata,
    output logic              grant_owner,
    output logic              id_valid,
    output logic              id_match
);

`ifdef TAG_SYSID_ID_CHECK_EN
    typedef enum logic [2:0] {StIdle, StFetch, StResp, StBootFetch, StBootChk} state_e;
    localparam state_e ResetState = StBootFetch;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StResp} state_e;
    localparam state_e ResetState = StIdle;
`endif

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              id_valid_q, id_valid_d;
    logic              id_match_q, id_match_d;
    logic              pick;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        id_valid_d   = id_valid_q;
        id_match_d   = id_match_q;
        // On a tie the master that was not served last wins.
        pick         = (m0_read && m1_read) ? ~last_grant_q : m1_read;
        unique case (state_q)
            StIdle: begin
                if (m0_read || m1_read) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = pick ? m1_address : m0_address;
                    state_d      = StFetch;
                end
            end
            StFetch: begin
                data_d  = sysid_readdata;
                state_d = StResp;
            end
            StResp: begin
                if (grant_q) m1_rdata_d = data_q;
                else         m0_rdata_d = data_q;
                state_d = StIdle;
            end
`ifdef TAG_SYSID_ID_CHECK_EN
            StBootFetch: begin
                addr_d  = 1'b1;
                state_d = StBootChk;
            end
            StBootChk: begin
                id_valid_d = 1'b1;
                id_match_d = (sysid_readdata == EXPECTED_ID);
                state_d    = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ResetState;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= 1'b0;
            data_q       <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            id_valid_q   <= 1'b0;
            id_match_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            id_valid_q   <= id_valid_d;
            id_match_q   <= id_match_d;
        end
    end

    always_comb begin
        m0_waitrequest = !((state_q == StResp) && !grant_q);
        m1_waitrequest = !((state_q == StResp) && grant_q);
        m0_readdata    = (!m0_waitrequest) ? data_q : m0_rdata_q;
        m1_readdata    = (!m1_waitrequest) ? data_q : m1_rdata_q;
        sysid_address  = addr_q;
        grant_owner    = grant_q;
    end

`ifdef TAG_SYSID_ID_CHECK_EN
    assign id_valid = id_valid_q;
    assign id_match = id_match_q;
`else
    logic unused_id_check;
    assign unused_id_check = ^{EXPECTED_ID, id_valid_q, id_match_q};
    assign id_valid        = 1'b0;
    assign id_match        = 1'b0;
`endif

endmodule
